// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the instruction-fetch front end:
//   - XLEN / INSTR_W : address and instruction widths
//   - PC_INC         : sequential fetch increment (one 32-bit instruction)
//   - fetch_state_e  : 3-bit fetch sequencer state encoding
//   - align_pc()     : forces a redirect target onto a word boundary
// ---------------------------------------------------------------------------
package rv32i_pkg;

   localparam int          XLEN    = 32;
   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_INC  = 32'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_DELIVER = 3'd3,
      ST_HALTED  = 3'd4
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
// Program-counter register for the fetch sequencer. Loads i_next_pc when
// i_en is high; returns to RESET_PC on synchronous reset.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   i_en      in   load enable
//   i_next_pc in   value to load
//   o_pc      out  current program counter
// ---------------------------------------------------------------------------
module fetch_pc_reg
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic [XLEN-1:0] i_next_pc,
   output logic [XLEN-1:0] o_pc
);

   logic [XLEN-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (i_en) begin
         r_pc <= i_next_pc;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Single-outstanding instruction fetch sequencer. Requests one word from
// instruction memory, offers it downstream until accepted, then fetches the
// next sequential word. Redirects restart fetch at a new aligned address,
// draining any in-flight request first; halt parks the sequencer until resume.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  memory request and fetch address (out)
//   imem_ack/imem_rdata memory response (in)
//   if_valid/if_instr/if_pc  instruction offered downstream (out)
//   id_ready            downstream accept (in)
//   redirect_valid/redirect_pc  control-flow redirect (in)
//   halt_req/resume     stop / restart fetching (in)
//   fetch_cnt           number of accepted instructions, wrapping (out)
// ---------------------------------------------------------------------------
module fetch_sequencer
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [XLEN-1:0]    if_pc,
   input  logic               id_ready,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   input  logic               halt_req,
   input  logic               resume,
   output logic [31:0]        fetch_cnt
);

   fetch_state_e       r_state;
   logic               r_imem_req;
   logic               r_if_valid;
   logic [INSTR_W-1:0] r_if_instr;
   logic [XLEN-1:0]    r_if_pc;
   logic [31:0]        r_fetch_cnt;

   logic               w_pc_en;
   logic [XLEN-1:0]    w_pc_next;
   logic [XLEN-1:0]    w_pc;

   // PC update decode: a redirect wins everywhere except HALTED; otherwise
   // the PC only advances when a fetch completes.
   always_comb begin
      w_pc_en   = 1'b0;
      w_pc_next = w_pc;
      if (r_state != ST_HALTED) begin
         if (redirect_valid) begin
            w_pc_en   = 1'b1;
            w_pc_next = align_pc(redirect_pc);
         end else if (r_state == ST_FETCH && imem_ack) begin
            w_pc_en   = 1'b1;
            w_pc_next = w_pc + PC_INC;
         end
      end
   end

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_pc_en),
      .i_next_pc (w_pc_next),
      .o_pc      (w_pc)
   );

   // Control FSM; imem_req and if_valid are registered alongside the state so
   // they are high exactly while the state is FETCH / DELIVER respectively.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_imem_req  <= 1'b0;
         r_if_valid  <= 1'b0;
         r_if_instr  <= '0;
         r_if_pc     <= '0;
         r_fetch_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!redirect_valid && halt_req) begin
                  r_state    <= ST_HALTED;
                  r_imem_req <= 1'b0;
               end else begin
                  r_state    <= ST_FETCH;
                  r_imem_req <= 1'b1;
               end
            end

            ST_FETCH: begin
               if (redirect_valid) begin
                  // Same-cycle ack: data is dropped, refetch at the target.
                  // Otherwise the request is still in flight and must drain.
                  if (imem_ack) begin
                     r_state    <= ST_FETCH;
                     r_imem_req <= 1'b1;
                  end else begin
                     r_state    <= ST_DRAIN;
                     r_imem_req <= 1'b0;
                  end
               end else if (imem_ack) begin
                  r_if_instr <= imem_rdata;
                  r_if_pc    <= w_pc;
                  r_state    <= ST_DELIVER;
                  r_imem_req <= 1'b0;
                  r_if_valid <= 1'b1;
               end
            end

            ST_DRAIN: begin
               // The stale response is swallowed; any redirect here only
               // moves the PC (handled in the PC decode).
               if (imem_ack) begin
                  r_state    <= ST_FETCH;
                  r_imem_req <= 1'b1;
               end
            end

            ST_DELIVER: begin
               if (redirect_valid) begin
                  if (id_ready) begin
                     r_fetch_cnt <= r_fetch_cnt + 32'd1;
                  end
                  r_if_valid <= 1'b0;
                  r_state    <= ST_FETCH;
                  r_imem_req <= 1'b1;
               end else if (id_ready) begin
                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
                  r_if_valid  <= 1'b0;
                  if (halt_req) begin
                     r_state    <= ST_HALTED;
                     r_imem_req <= 1'b0;
                  end else begin
                     r_state    <= ST_FETCH;
                     r_imem_req <= 1'b1;
                  end
               end
            end

            ST_HALTED: begin
               if (resume) begin
                  r_state    <= ST_FETCH;
                  r_imem_req <= 1'b1;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_imem_req <= 1'b0;
               r_if_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = w_pc;
   assign if_valid  = r_if_valid;
   assign if_instr  = r_if_instr;
   assign if_pc     = r_if_pc;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. The bench plays instruction memory
// and the decode stage; a behavioural model tracks what the sequencer should
// be doing (request in flight, drain pending, instruction on offer, halted)
// and every cycle all outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        resume;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   // Model state
   bit          m_idle, m_req, m_drain, m_offer, m_halted;
   logic [31:0] m_pc, m_instr, m_ipc, m_cnt;

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .resume         (resume),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge of the reference behaviour, using the inputs as sampled.
   task automatic model_edge();
      if (rst) begin
         m_idle = 1; m_req = 0; m_drain = 0; m_offer = 0; m_halted = 0;
         m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
      end else if (m_halted) begin
         if (resume) begin
            m_halted = 0; m_req = 1;
         end
      end else if (m_idle) begin
         m_idle = 0;
         if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC; m_req = 1;
         end else if (halt_req) begin
            m_halted = 1;
         end else begin
            m_req = 1;
         end
      end else if (redirect_valid) begin
         m_pc = redirect_pc & 32'hFFFF_FFFC;
         if (m_offer) begin
            if (id_ready) m_cnt = m_cnt + 1;
            m_offer = 0; m_req = 1;
         end else if (m_req) begin
            if (!imem_ack) begin
               m_req = 0; m_drain = 1;
            end
         end else if (m_drain && imem_ack) begin
            m_drain = 0; m_req = 1;
         end
      end else if (m_req) begin
         if (imem_ack) begin
            m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4;
            m_req = 0; m_offer = 1;
         end
      end else if (m_drain) begin
         if (imem_ack) begin
            m_drain = 0; m_req = 1;
         end
      end else if (m_offer && id_ready) begin
         m_cnt = m_cnt + 1; m_offer = 0;
         if (halt_req) m_halted = 1;
         else m_req = 1;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("imem_req",  {31'b0, imem_req}, {31'b0, m_req});
      check("imem_addr", imem_addr, m_pc);
      check("if_valid",  {31'b0, if_valid}, {31'b0, m_offer});
      if (m_offer || rst) begin
         check("if_instr", if_instr, m_instr);
         check("if_pc",    if_pc,    m_ipc);
      end
      check("fetch_cnt", fetch_cnt, m_cnt);
   endtask

   task automatic clear_inputs();
      imem_ack = 0; imem_rdata = 32'h0; id_ready = 0; redirect_valid = 0;
      redirect_pc = 32'h0; halt_req = 0; resume = 0;
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      // Reset state
      cyc();
      cyc();
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_instr", if_instr, 32'd0);
      rst = 0;

      // First fetch at 0, accept, next address 4
      cyc();
      check("first_addr", imem_addr, 32'h0);
      imem_ack = 1; imem_rdata = 32'h0000_0013;
      cyc();
      imem_ack = 0;
      check("first_valid", {31'b0, if_valid}, 32'd1);
      check("first_pc", if_pc, 32'h0);
      // Downstream stalls for 5 cycles
      repeat (5) cyc();
      check("stall_instr", if_instr, 32'h0000_0013);
      id_ready = 1;
      cyc();
      id_ready = 0;
      check("accept_addr", imem_addr, 32'h4);
      check("accept_cnt", fetch_cnt, 32'd1);

      // Fetch at 4, accept, then redirect while fetch at 8 is outstanding
      imem_ack = 1; imem_rdata = $urandom;
      cyc();
      imem_ack = 0; id_ready = 1;
      cyc();
      id_ready = 0;
      cyc();
      check("out_addr", imem_addr, 32'h8);
      redirect_valid = 1; redirect_pc = 32'h0000_0103;
      cyc();
      redirect_valid = 0;
      check("drain_req", {31'b0, imem_req}, 32'd0);
      cyc();
      imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
      imem_ack = 0;
      check("redir_addr", imem_addr, 32'h100);
      check("drain_valid", {31'b0, if_valid}, 32'd0);

      // Redirect together with ack: data dropped
      redirect_valid = 1; redirect_pc = 32'h0000_0200; imem_ack = 1; imem_rdata = 32'h1234_5678;
      cyc();
      clear_inputs();
      check("same_valid", {31'b0, if_valid}, 32'd0);
      check("same_addr", imem_addr, 32'h200);

      // Halt after accept, ignored redirect, resume at unchanged PC
      imem_ack = 1; imem_rdata = $urandom;
      cyc();
      imem_ack = 0; id_ready = 1; halt_req = 1;
      cyc();
      clear_inputs();
      redirect_valid = 1; redirect_pc = 32'h0000_0500;
      repeat (3) cyc();
      check("halt_req", {31'b0, imem_req}, 32'd0);
      redirect_valid = 0; resume = 1;
      cyc();
      resume = 0;
      check("resume_addr", imem_addr, 32'h204);

      // Counter wrap
      imem_ack = 1; imem_rdata = $urandom;
      cyc();
      imem_ack = 0;
      force dut.r_fetch_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_fetch_cnt;
      m_cnt = 32'hFFFF_FFFF;
      id_ready = 1;
      cyc();
      id_ready = 0;
      check("wrap_cnt", fetch_cnt, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 199) == 0);
         imem_ack       = ($urandom_range(0, 99) < 40);
         imem_rdata     = $urandom;
         id_ready       = ($urandom_range(0, 99) < 50);
         redirect_valid = ($urandom_range(0, 99) < 8);
         redirect_pc    = $urandom;
         halt_req       = ($urandom_range(0, 99) < 10);
         resume         = ($urandom_range(0, 99) < 20);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  read data valid.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  instruction offered downstream.
- if_instr  out  32  offered instruction.
- if_pc  out  32  address of the offered instruction.
- id_ready  in  1  downstream accepts this cycle.
- redirect_valid  in  1  branch, jump or trap redirect.
- redirect_pc  in  32  redirect target.
- halt_req  in  1  stop fetching.
- resume  in  1  leave the halted state.
- fetch_cnt  out  32  count of instructions accepted downstream.

Function
REQ-003 SHALL implement the states IDLE, FETCH, DRAIN, DELIVER and HALTED, encoded in 3 bits.
REQ-004 SHALL hold an internal 32-bit fetch PC that drives imem_addr and updates only in the transitions listed below.
REQ-005 IDLE: SHALL go to FETCH the next cycle; imem_req=0.
REQ-006 FETCH: imem_req=1 and imem_addr SHALL stay stable until imem_ack; on imem_ack, if_instr<=imem_rdata, if_pc<=PC, PC<=PC+4 (mod 2^32), go to DELIVER.
REQ-007 DELIVER: if_valid=1 with if_instr/if_pc stable; on id_ready, fetch_cnt increments and the block goes to FETCH, so imem_req reasserts the next cycle.
REQ-008 SHALL have at most one outstanding memory request; imem_ack outside FETCH/DRAIN SHALL be ignored.
REQ-009 redirect_valid SHALL take priority over every other event in all states except HALTED: PC<={redirect_pc[31:2],2'b00}, and if_valid SHALL be 0 from the next cycle.
REQ-010 Redirect in FETCH without a same-cycle imem_ack SHALL go to DRAIN; DRAIN holds imem_req=0 and discards the next imem_ack, then goes to FETCH.
REQ-011 Redirect in FETCH with a same-cycle imem_ack SHALL discard imem_rdata and go to FETCH at the new PC.
REQ-012 Redirect in DELIVER with a same-cycle id_ready SHALL still count the accept, then go to FETCH.
REQ-013 Redirect in DRAIN SHALL update PC and remain in DRAIN unless imem_ack is high the same cycle, in which case it goes to FETCH.
REQ-014 halt_req SHALL be lower priority than redirect_valid and SHALL be taken only in IDLE or DELIVER after id_ready, or in FETCH after imem_ack (instruction placed in DELIVER first); it then goes to HALTED with imem_req=0 and if_valid=0.
REQ-015 HALTED: SHALL ignore redirect_valid and go to FETCH at the unchanged PC on resume.
REQ-016 fetch_cnt SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-017 With rst high at a clk edge: state=IDLE, PC=RESET_PC, if_valid=0, imem_req=0, if_instr=0, if_pc=0, fetch_cnt=0.
REQ-018 Reset mid-request SHALL abandon the request; the pending imem_ack SHALL be ignored because the state is IDLE.
REQ-019 rst SHALL override every other input.

Structure
REQ-020 SHALL place the state encoding, the instruction width and the PC increment (4) in the shared package rv32i_pkg.
REQ-021 SHALL instantiate the program-counter register sub-module fetch_pc_reg, with EN and next-PC driven by this block's FSM.

Verification
REQ-022 Reset, then a 1-cycle imem_ack with rdata 32'h00000013 -> imem_addr=0; if_valid=1 with if_pc=0; after id_ready, imem_addr=4 and fetch_cnt=1.
REQ-023 id_ready held low for 5 cycles in DELIVER -> if_instr/if_pc stable, imem_req=0, fetch_cnt unchanged.
REQ-024 redirect_pc=32'h00000103 while a fetch at 8 is outstanding -> DRAIN; the next ack is discarded; next imem_addr=32'h00000100.
REQ-025 redirect_valid and imem_ack in the same cycle -> data not offered (if_valid stays 0); next imem_addr=redirect target.
REQ-026 halt_req in DELIVER with id_ready, then resume after 3 cycles -> imem_req=0 while HALTED; fetch restarts at the unchanged PC; redirect during HALTED has no effect.
REQ-027 Preload fetch_cnt to 32'hFFFFFFFF via accepts (or force) and perform one more accept -> fetch_cnt=0.
